svm_stage1_sequencer: RTL and testbench

SVM_STAGE1_SEQUENCER -- requirements
Module: svm_stage1_sequencer

---
 rtl/svm_pkg.sv | 29 ++
 rtl/svm_stage1_sequencer_if.sv | 33 +++
 rtl/svm_seq_counter.sv | 33 +++
 rtl/svm_stage1_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_svm_stage1_sequencer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/svm_pkg.sv
// svm_pkg: constants and types shared by the SVM stage-1 control slice.
// The sequencer FSM state encoding lives here so the top module and any
// future debug/observation logic agree on one definition.
package svm_pkg;

    localparam int XLEN_PIXEL    = 8;   // bits per pixel in the vector RAMs
    localparam int NUM_OF_PIXELS = 4;   // pixels per test / support vector
    localparam int NUM_OF_SV     = 4;   // number of support vectors (parallel slices)
    localparam int RD_LAT        = 1;   // RAM read latency in cycles
    localparam int MAC_LAT       = 2;   // slice input-to-accumulator latency
    localparam int ADDR_W        = 8;   // pixel address width

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        COMPUTE,
        DRAIN,
        CAPTURE,
        DECIDE,
        DONE
    } svm_state_e;

    // Cycles spent between the last read issue and the kernel capture.
    function automatic int drain_cycles(input int rd_lat, input int mac_lat);
        return rd_lat + mac_lat;
    endfunction

endpackage

// File: rtl/svm_stage1_sequencer_if.sv
// svm_stage1_sequencer_if: control/handshake bundle between the stage-1
// sequencer (master) and the RAMs, dot-product slices and decision block
// around it (slave).
interface svm_stage1_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              abort;
    logic              pix_valid;
    logic              pix_ready;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic              mac_clr;
    logic              stall_MEM;
    logic              kernel_capture;
    logic              decision_funct_en;
    logic              dec_valid;
    logic              busy;
    logic              done;

    modport master (
        input  start, abort, pix_valid, dec_valid,
        output pix_ready, ram_we, ram_re, ram_addr, mac_clr, stall_MEM,
               kernel_capture, decision_funct_en, busy, done
    );

    modport slave (
        output start, abort, pix_valid, dec_valid,
        input  pix_ready, ram_we, ram_re, ram_addr, mac_clr, stall_MEM,
               kernel_capture, decision_funct_en, busy, done
    );
endinterface

// File: rtl/svm_seq_counter.sv
// svm_seq_counter: small up-counter with synchronous clear and load and a
// terminal-count flag. It saturates at MAX so it can never run past the
// last valid index.
module svm_seq_counter #(
    parameter int W   = 8,
    parameter int MAX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = (count == W'(MAX));

    // Count register: clear beats load beats increment; hold at MAX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && !tc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/svm_stage1_sequencer.sv
// svm_stage1_sequencer: control FSM for the SVM first stage. It loads a test
// vector into RAM, streams every pixel address to the support-vector RAMs
// while the dot-product slices accumulate, waits out the read + MAC pipeline,
// captures the kernel results and hands over to the decision function.
// Every output is a flop; nothing combinational reaches a port.
module svm_stage1_sequencer
    import svm_pkg::*;
#(
    parameter int NUM_OF_PIXELS = svm_pkg::NUM_OF_PIXELS,
    parameter int RD_LAT        = svm_pkg::RD_LAT,
    parameter int MAC_LAT       = svm_pkg::MAC_LAT,
    parameter int ADDR_W        = svm_pkg::ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    svm_stage1_sequencer_if.master bus
);

    svm_state_e        state;

    logic              pix_ready_q;
    logic              ram_we_q;
    logic              ram_re_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              mac_clr_q;
    logic              kernel_capture_q;
    logic              dec_en_q;
    logic              busy_q;
    logic              done_q;

    // stall_pipe[0] is "no read issued last cycle"; the oldest stage drives
    // stall_MEM so the slices run exactly while read data is arriving.
    logic [RD_LAT-1:0] stall_pipe;

    logic [ADDR_W-1:0] pix_count;
    logic              pix_tc;
    logic [ADDR_W-1:0] drain_count;
    logic              drain_tc;

    logic              abort_now;
    logic              pix_clr;
    logic              pix_inc;
    logic              drain_clr;
    logic              drain_inc;

    // Counter control decoded from the current state and the live inputs.
    // NOTE: every signal gets a default before the conditions so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        abort_now = 1'b0;
        pix_clr   = 1'b0;
        pix_inc   = 1'b0;
        drain_clr = 1'b1;
        drain_inc = 1'b0;

        abort_now = bus.abort && (state != IDLE);
        pix_clr   = abort_now || (state == IDLE) || (state == CLEAR);
        pix_inc   = !abort_now && !pix_tc &&
                    (((state == LOAD) && bus.pix_valid) || (state == COMPUTE));
        drain_clr = abort_now || (state != DRAIN);
        drain_inc = (state == DRAIN) && !drain_tc;
    end

    svm_seq_counter #(
        .W   (ADDR_W),
        .MAX (NUM_OF_PIXELS - 1)
    ) u_pix_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (pix_clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (pix_inc),
        .count    (pix_count),
        .tc       (pix_tc)
    );

    svm_seq_counter #(
        .W   (ADDR_W),
        .MAX (drain_cycles(RD_LAT, MAC_LAT) - 1)
    ) u_drain_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (drain_clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (drain_inc),
        .count    (drain_count),
        .tc       (drain_tc)
    );

    // Sequencer FSM with all port values registered alongside the state.
    // NOTE: non-blocking assignments throughout, so every flop here samples
    // the pre-edge values no matter the statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            pix_ready_q      <= 1'b0;
            ram_we_q         <= 1'b0;
            ram_re_q         <= 1'b0;
            ram_addr_q       <= '0;
            mac_clr_q        <= 1'b0;
            kernel_capture_q <= 1'b0;
            dec_en_q         <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            // NOTE: this delay line must come out of reset reading "stalled",
            // so unlike a RAM array it is reset like any other control flop.
            stall_pipe       <= '1;
        end else begin
            // Single-cycle strobes default low each cycle.
            ram_we_q         <= 1'b0;
            mac_clr_q        <= 1'b0;
            kernel_capture_q <= 1'b0;
            done_q           <= 1'b0;

            for (int i = RD_LAT - 1; i > 0; i--) begin
                stall_pipe[i] <= stall_pipe[i-1];
            end
            stall_pipe[0] <= ~ram_re_q;

            if (abort_now) begin
                // Abort beats every other transition and flushes the slices.
                state       <= IDLE;
                pix_ready_q <= 1'b0;
                ram_re_q    <= 1'b0;
                ram_addr_q  <= '0;
                dec_en_q    <= 1'b0;
                busy_q      <= 1'b0;
                stall_pipe  <= '1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state       <= LOAD;
                            pix_ready_q <= 1'b1;
                            busy_q      <= 1'b1;
                        end
                    end
                    LOAD: begin
                        // The write lands the cycle after the pixel is taken.
                        if (bus.pix_valid) begin
                            ram_we_q   <= 1'b1;
                            ram_addr_q <= pix_count;
                            if (pix_tc) begin
                                state       <= CLEAR;
                                pix_ready_q <= 1'b0;
                                mac_clr_q   <= 1'b1;
                            end
                        end
                    end
                    CLEAR: begin
                        state      <= COMPUTE;
                        ram_re_q   <= 1'b1;
                        ram_addr_q <= '0;
                    end
                    COMPUTE: begin
                        if (pix_tc) begin
                            state    <= DRAIN;
                            ram_re_q <= 1'b0;
                        end else begin
                            ram_addr_q <= pix_count + ADDR_W'(1);
                        end
                    end
                    DRAIN: begin
                        if (drain_tc) begin
                            state            <= CAPTURE;
                            kernel_capture_q <= 1'b1;
                        end
                    end
                    CAPTURE: begin
                        state    <= DECIDE;
                        dec_en_q <= 1'b1;
                    end
                    DECIDE: begin
                        if (bus.dec_valid) begin
                            state    <= DONE;
                            dec_en_q <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
                    DONE: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.pix_ready         = pix_ready_q;
    assign bus.ram_we            = ram_we_q;
    assign bus.ram_re            = ram_re_q;
    assign bus.ram_addr          = ram_addr_q;
    assign bus.mac_clr           = mac_clr_q;
    assign bus.stall_MEM         = stall_pipe[RD_LAT-1];
    assign bus.kernel_capture    = kernel_capture_q;
    assign bus.decision_funct_en = dec_en_q;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;

endmodule

// File: tb/tb_svm_stage1_sequencer.sv
// tb_svm_stage1_sequencer: randomized directed runs of the stage-1 sequencer.
// Each run draws an input schedule, derives the expected output timeline
// from the sequencing rules (load handshakes, clear, read burst, drain,
// capture, decide, done; abort or reset truncating it) and compares every
// cycle against the DUT.
module tb_svm_stage1_sequencer;

    localparam int N   = 4;
    localparam int RD  = 1;
    localparam int MAC = 2;
    localparam int AW  = 8;
    localparam int SZ  = 256;

    typedef struct packed {
        logic          pix_ready;
        logic          ram_we;
        logic          ram_re;
        logic [AW-1:0] ram_addr;
        logic          mac_clr;
        logic          stall;
        logic          kcap;
        logic          dec_en;
        logic          busy;
        logic          done;
    } outs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    svm_stage1_sequencer_if #(.ADDR_W(AW)) bus ();

    svm_stage1_sequencer #(
        .NUM_OF_PIXELS (N),
        .RD_LAT        (RD),
        .MAC_LAT       (MAC),
        .ADDR_W        (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // Per-run input schedule and derived timeline (cycle indices).
    bit pv [SZ];
    bit st [SZ];
    bit av [SZ];
    bit dv [SZ];
    int acc [N];
    int c_cyc;
    int k_cyc;
    int d_cyc;
    int ab_x;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic outs_t idle_outs();
        outs_t e;
        e       = '0;
        e.stall = 1'b1;
        return e;
    endfunction

    // Expected outputs in cycle t of the current run (cycle 0 = start cycle).
    function automatic outs_t expect_at(input int t);
        outs_t e;
        e = idle_outs();
        if (t == 0 || t >= d_cyc + 2) return e;
        if (ab_x >= 0 && t > ab_x) return e;
        e.busy = 1'b1;
        if (t >= 1 && t <= acc[N-1]) e.pix_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (t == acc[i] + 1) begin
                e.ram_we   = 1'b1;
                e.ram_addr = AW'(i);
            end
        end
        if (t == c_cyc) e.mac_clr = 1'b1;
        if (t >= c_cyc + 1 && t <= c_cyc + N) begin
            e.ram_re   = 1'b1;
            e.ram_addr = AW'(t - c_cyc - 1);
        end
        if (t >= c_cyc + 1 + RD && t <= c_cyc + N + RD) e.stall = 1'b0;
        if (t == k_cyc) e.kcap = 1'b1;
        if (t >= k_cyc + 1 && t <= d_cyc) e.dec_en = 1'b1;
        if (t == d_cyc + 1) e.done = 1'b1;
        return e;
    endfunction

    function automatic outs_t observe();
        outs_t o;
        o.pix_ready = bus.pix_ready;
        o.ram_we    = bus.ram_we;
        o.ram_re    = bus.ram_re;
        o.ram_addr  = bus.ram_addr;
        o.mac_clr   = bus.mac_clr;
        o.stall     = bus.stall_MEM;
        o.kcap      = bus.kernel_capture;
        o.dec_en    = bus.decision_funct_en;
        o.busy      = bus.busy;
        o.done      = bus.done;
        return o;
    endfunction

    // The address bus is only meaningful while a RAM strobe is expected.
    task automatic check_cycle(input string tag, input int t, input outs_t e);
        outs_t o;
        o = observe();
        if (!(e.ram_we || e.ram_re)) begin
            o.ram_addr = '0;
            e.ram_addr = '0;
        end
        check($sformatf("%s@%0d", tag, t), 32'(o), 32'(e));
    endtask

    task automatic drive_idle();
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.pix_valid = 1'b0;
        bus.dec_valid = 1'b0;
    endtask

    // abort_mode: 0 none, 1 at read address 2, 2 together with dec_valid,
    // 3 at a random busy cycle.
    task automatic run_case(input string name, input int pct, input bit fixed_pv,
                            input int dec_delay, input int abort_mode,
                            input bit rst_mid, input bit extra_starts);
        bit pat [7];
        int n;
        int last;
        int x;
        int dones;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        for (int t = 0; t < SZ; t++) begin
            st[t] = 1'b0;
            av[t] = 1'b0;
            dv[t] = 1'b0;
            pv[t] = ($urandom_range(1, 100) <= pct) || (t > 40);
        end
        if (fixed_pv) begin
            for (int t = 0; t < 7; t++) pv[t+1] = pat[t];
        end

        n = 0;
        for (int t = 1; t < SZ && n < N; t++) begin
            if (pv[t]) begin
                acc[n] = t;
                n++;
            end
        end
        c_cyc = acc[N-1] + 1;
        k_cyc = c_cyc + N + RD + MAC + 1;
        d_cyc = k_cyc + 1 + dec_delay;

        st[0] = 1'b1;
        for (int t = 0; t <= k_cyc; t++) dv[t] = ($urandom_range(0, 3) == 0);
        dv[d_cyc] = 1'b1;

        ab_x = -1;
        case (abort_mode)
            1:       ab_x = c_cyc + 3;
            2:       ab_x = d_cyc;
            3:       ab_x = $urandom_range(1, d_cyc + 1);
            default: ab_x = -1;
        endcase
        if (ab_x >= 0) av[ab_x] = 1'b1;
        x = rst_mid ? c_cyc + N + 2 : -1;

        if (extra_starts) begin
            for (int t = 1; t <= d_cyc; t++) st[t] = ($urandom_range(0, 4) == 0);
            st[c_cyc + 2] = 1'b1;
            st[d_cyc + 1] = 1'b1;
        end

        last = (ab_x >= 0) ? ab_x + 1 : d_cyc + 2;
        for (int t = last; t < SZ; t++) begin
            st[t] = 1'b0;
            av[t] = 1'b0;
            dv[t] = 1'b0;
            pv[t] = 1'b0;
        end

        dones = 0;
        for (int t = 0; t <= last; t++) begin
            @(negedge clk);
            check_cycle(name, t, expect_at(t));
            dones += int'(bus.done);
            bus.start     = st[t];
            bus.abort     = av[t];
            bus.pix_valid = pv[t];
            bus.dec_valid = dv[t];
            if (rst_mid && t == x) begin
                #2 rst = 1'b0;
                #1 check_cycle({name, "_async_rst"}, t, idle_outs());
                break;
            end
        end
        check({name, "_done_count"}, 32'(dones),
              ((ab_x >= 0 && ab_x <= d_cyc) || rst_mid) ? 32'd0 : 32'd1);

        drive_idle();
        if (rst_mid) begin
            repeat (2) begin
                @(negedge clk);
                check_cycle({name, "_in_rst"}, 0, idle_outs());
            end
            rst = 1'b1;
        end
    endtask

    initial begin
        drive_idle();
        #1 rst = 1'b0;
        #11;
        check_cycle("reset", 0, idle_outs());
        check("reset_addr", 32'(bus.ram_addr), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_case("nominal",       100, 1'b0, 2, 0, 1'b0, 1'b0);
        run_case("load_gaps",     100, 1'b1, 1, 0, 1'b0, 1'b0);
        run_case("abort_compute", 100, 1'b0, 1, 1, 1'b0, 1'b0);
        run_case("rst_drain",     100, 1'b0, 1, 0, 1'b1, 1'b0);
        run_case("after_rst",     100, 1'b0, 2, 0, 1'b0, 1'b0);
        run_case("start_noise",    70, 1'b0, 3, 0, 1'b0, 1'b1);
        run_case("dec_abort",     100, 1'b0, 2, 2, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            run_case($sformatf("rand%0d", i), $urandom_range(30, 100), 1'b0,
                     $urandom_range(0, 5), ($urandom_range(0, 2) == 0) ? 3 : 0,
                     1'b0, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
